// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus types: access direction, response status and host adapter FSM states.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } rggen_adapter_state;

  // Both error encodings have the upper bit set; OKAY/EXOKAY do not.
  function automatic logic rggen_is_error(rggen_status status);
    return status[1];
  endfunction

endpackage

// File: rtl/rggen_or_reducer.sv
// OR-reduces N WIDTH-bit slices, keeping only the slices whose mask bit is set.
module rggen_or_reducer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4
) (
  input  logic [N-1:0]       i_mask,
  input  logic [WIDTH*N-1:0] i_data,
  output logic [WIDTH-1:0]   o_data_c
);

  // Masked OR across all slices.
  always_comb begin
    o_data_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (i_mask[i]) begin
        o_data_c = o_data_c | i_data[WIDTH*i +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/rggen_apb_host_adapter.sv
// APB3/APB4 slave to internal register-bus bridge with decode-error and watchdog timeout.
module rggen_apb_host_adapter
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned REGISTERS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic [ADDRESS_WIDTH-1:0]       i_paddr,
  input  logic [2:0]                     i_pprot,
  input  logic                           i_pwrite,
  input  logic [BUS_WIDTH/8-1:0]         i_pstrb,
  input  logic [BUS_WIDTH-1:0]           i_pwdata,
  output logic                           o_pready,
  output logic [BUS_WIDTH-1:0]           o_prdata,
  output logic                           o_pslverr,
  output logic                           o_reg_valid,
  output rggen_direction                 o_reg_direction,
  output logic [ADDRESS_WIDTH-1:0]       o_reg_address,
  output logic [BUS_WIDTH-1:0]           o_reg_write_data,
  output logic [BUS_WIDTH-1:0]           o_reg_strobe,
  input  logic [REGISTERS-1:0]           i_reg_active,
  input  logic [REGISTERS-1:0]           i_reg_ready,
  input  logic [2*REGISTERS-1:0]         i_reg_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_reg_read_data
);

  localparam int unsigned STRB_W = BUS_WIDTH / 8;
  localparam int unsigned LSB_W  = $clog2(STRB_W);
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'((2 ** LSB_W) - 1);

  // Protection attributes carry no meaning for the register blocks.
  logic unused_pprot;
  assign unused_pprot = ^i_pprot;

  rggen_adapter_state          state_q, state_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        valid_q, valid_d;
  rggen_direction              dir_q, dir_d;
  logic [ADDRESS_WIDTH-1:0]    addr_q, addr_d;
  logic [BUS_WIDTH-1:0]        wdata_q, wdata_d;
  logic [BUS_WIDTH-1:0]        strobe_q, strobe_d;
  logic                        pready_q, pready_d;
  logic                        pslverr_q, pslverr_d;
  logic [BUS_WIDTH-1:0]        prdata_q, prdata_d;

  logic [BUS_WIDTH-1:0]        data_or_c;
  logic [1:0]                  status_or_c;
  logic                        timeout_hit_c;
  logic                        resp_done_c;
  rggen_status                 resp_status_c;
  logic [BUS_WIDTH-1:0]        resp_data_c;

  rggen_or_reducer #(
    .WIDTH (BUS_WIDTH),
    .N     (REGISTERS)
  ) u_data_reducer (
    .i_mask   (i_reg_active),
    .i_data   (i_reg_read_data),
    .o_data_c (data_or_c)
  );

  rggen_or_reducer #(
    .WIDTH (2),
    .N     (REGISTERS)
  ) u_status_reducer (
    .i_mask   (i_reg_active),
    .i_data   (i_reg_status),
    .o_data_c (status_or_c)
  );

  assign timeout_hit_c = (TIMEOUT_CYCLES != 0) &&
                         (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Response selection: decode error, then slice ready, then watchdog expiry.
  always_comb begin
    resp_done_c   = 1'b0;
    resp_status_c = RGGEN_OKAY;
    resp_data_c   = '0;
    if (i_reg_active == '0) begin
      resp_done_c   = 1'b1;
      resp_status_c = RGGEN_DECODE_ERROR;
    end else if (|(i_reg_active & i_reg_ready)) begin
      resp_done_c   = 1'b1;
      resp_status_c = rggen_status'(status_or_c);
      resp_data_c   = data_or_c;
    end else if (timeout_hit_c) begin
      resp_done_c   = 1'b1;
      resp_status_c = RGGEN_SLAVE_ERROR;
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_psel && !i_penable) state_d = ACCESS;
      ACCESS:  if (resp_done_c)          state_d = RESPOND;
      RESPOND:                           state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Output/datapath next values: command capture, watchdog count and APB response.
  always_comb begin
    count_d   = count_q;
    dir_d     = dir_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strobe_d  = strobe_q;
    valid_d   = (state_d == ACCESS);
    pready_d  = (state_d == RESPOND);
    pslverr_d = 1'b0;
    prdata_d  = '0;

    if ((state_q == IDLE) && (state_d == ACCESS)) begin
      count_d = '0;
      dir_d   = i_pwrite ? RGGEN_WRITE : RGGEN_READ;
      addr_d  = i_paddr & ADDR_MASK;
      wdata_d = i_pwdata;
      for (int i = 0; i < int'(STRB_W); i++) begin
        strobe_d[8*i +: 8] = {8{i_pstrb[i]}};
      end
      if (!i_pwrite) begin
        strobe_d = '1;
      end
    end

    if (state_q == ACCESS) begin
      if (count_q != '1) begin
        count_d = count_q + CNT_W'(1);
      end
      if (state_d == RESPOND) begin
        pslverr_d = rggen_is_error(resp_status_c);
        if ((dir_q == RGGEN_READ) && !rggen_is_error(resp_status_c)) begin
          prdata_d = resp_data_c;
        end
      end
    end
  end

  // Output and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q   <= '0;
      valid_q   <= 1'b0;
      dir_q     <= RGGEN_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      strobe_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      count_q   <= count_d;
      valid_q   <= valid_d;
      dir_q     <= dir_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strobe_q  <= strobe_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign o_pready         = pready_q;
  assign o_pslverr        = pslverr_q;
  assign o_prdata         = prdata_q;
  assign o_reg_valid      = valid_q;
  assign o_reg_direction  = dir_q;
  assign o_reg_address    = addr_q;
  assign o_reg_write_data = wdata_q;
  assign o_reg_strobe     = strobe_q;

endmodule

// File: tb/tb_rggen_apb_host_adapter.sv
// Directed bench for the APB host adapter; cycle 1 is the first ACCESS cycle after setup.
module tb_rggen_apb_host_adapter;
  import rggen_rtl_pkg::*;

  logic        clk;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        reg_valid;
  rggen_direction reg_dir;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata, reg_strobe;
  logic [3:0]  reg_active, reg_ready;
  logic [7:0]  reg_status;
  logic [127:0] reg_rdata;

  int errors = 0;
  int checks = 0;

  rggen_apb_host_adapter #(
    .ADDRESS_WIDTH  (16),
    .BUS_WIDTH      (32),
    .REGISTERS      (4),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_psel           (psel),
    .i_penable        (penable),
    .i_paddr          (paddr),
    .i_pprot          (pprot),
    .i_pwrite         (pwrite),
    .i_pstrb          (pstrb),
    .i_pwdata         (pwdata),
    .o_pready         (pready),
    .o_prdata         (prdata),
    .o_pslverr        (pslverr),
    .o_reg_valid      (reg_valid),
    .o_reg_direction  (reg_dir),
    .o_reg_address    (reg_addr),
    .o_reg_write_data (reg_wdata),
    .o_reg_strobe     (reg_strobe),
    .i_reg_active     (reg_active),
    .i_reg_ready      (reg_ready),
    .i_reg_status     (reg_status),
    .i_reg_read_data  (reg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one APB transfer; the slices respond with ready from access cycle rdy_cycle (0 = never).
  task automatic run_xfer(
    input  logic [15:0]  addr,
    input  logic         wr,
    input  logic [31:0]  wdata,
    input  logic [3:0]   strb,
    input  logic [3:0]   active,
    input  logic [3:0]   rdy_mask,
    input  int           rdy_cycle,
    input  logic [7:0]   status,
    input  logic [127:0] rdata,
    output int           pr_cycle,
    output int           v_cycles,
    output logic [31:0]  rd,
    output logic         err,
    output logic [15:0]  addr_seen,
    output logic [31:0]  strobe_seen,
    output logic [31:0]  wdata_seen,
    output logic         dir_seen
  );
    pr_cycle = 0; v_cycles = 0; rd = '0; err = 1'b0;
    addr_seen = '0; strobe_seen = '0; wdata_seen = '0; dir_seen = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb;
    pprot = 3'b010;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      reg_active = active;
      reg_ready  = (rdy_cycle != 0 && n >= rdy_cycle) ? rdy_mask : 4'b0000;
      reg_status = status;
      reg_rdata  = rdata;
      if (n == 1) begin
        addr_seen = reg_addr; strobe_seen = reg_strobe;
        wdata_seen = reg_wdata; dir_seen = reg_dir;
      end
      if (pready) begin
        pr_cycle = n; rd = prdata; err = pslverr;
        break;
      end
      if (reg_valid) v_cycles++;
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0; reg_active = '0; reg_ready = '0;
  endtask

  int          pc, vc;
  logic [31:0] rd, sb, wd;
  logic        er, dr;
  logic [15:0] ad;

  task automatic test_reset();
    psel = 0; penable = 0; paddr = 0; pprot = 0; pwrite = 0; pstrb = 0; pwdata = 0;
    reg_active = 0; reg_ready = 0; reg_status = 0; reg_rdata = 0;
    rst = 1'b1;
    #3;
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL reset_pready got %b want 0", pready); end
    checks++; if (reg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", reg_valid); end
    checks++; if (reg_dir !== RGGEN_READ) begin errors++; $display("FAIL reset_dir got %b want 0", reg_dir); end
    checks++; if ({prdata, pslverr, reg_addr, reg_wdata, reg_strobe} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {prdata, pslverr, reg_addr, reg_wdata, reg_strobe});
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_write_hit();
    run_xfer(16'h0004, 1'b1, 32'hA5A5_0F0F, 4'b0011, 4'b0010, 4'b0010, 1, 8'h00, 128'h0,
             pc, vc, rd, er, ad, sb, wd, dr);
    checks++; if (sb !== 32'h0000_FFFF) begin errors++; $display("FAIL wr_strobe got %h want 0000ffff", sb); end
    checks++; if (dr !== 1'b1) begin errors++; $display("FAIL wr_dir got %b want 1", dr); end
    checks++; if (ad !== 16'h0004) begin errors++; $display("FAIL wr_addr got %h want 0004", ad); end
    checks++; if (wd !== 32'hA5A5_0F0F) begin errors++; $display("FAIL wr_wdata got %h want a5a50f0f", wd); end
    checks++; if (pc !== 2) begin errors++; $display("FAIL wr_pready_cycle got %0d want 2", pc); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_pslverr got %b want 0", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_prdata got %h want 0", rd); end
    @(posedge clk); #1;
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL wr_pready_one_cycle got %b want 0", pready); end
  endtask

  task automatic test_read_wait();
    run_xfer(16'h000B, 1'b0, 32'hDEAD_BEEF, 4'b0000, 4'b0100, 4'b0100, 3, 8'h00,
             {32'h0, 32'h1234_5678, 32'hFFFF_0000, 32'h0000_00FF},
             pc, vc, rd, er, ad, sb, wd, dr);
    checks++; if (ad !== 16'h0008) begin errors++; $display("FAIL rd_addr_align got %h want 0008", ad); end
    checks++; if (sb !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rd_strobe got %h want ffffffff", sb); end
    checks++; if (dr !== 1'b0) begin errors++; $display("FAIL rd_dir got %b want 0", dr); end
    checks++; if (pc !== 4) begin errors++; $display("FAIL rd_pready_cycle got %0d want 4", pc); end
    checks++; if (vc !== 3) begin errors++; $display("FAIL rd_valid_cycles got %0d want 3", vc); end
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL rd_prdata got %h want 12345678", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_pslverr got %b want 0", er); end
  endtask

  task automatic test_decode_error();
    run_xfer(16'h0100, 1'b0, 32'h0, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00, {4{32'hCAFE_F00D}},
             pc, vc, rd, er, ad, sb, wd, dr);
    checks++; if (pc !== 2) begin errors++; $display("FAIL dec_pready_cycle got %0d want 2", pc); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL dec_pslverr got %b want 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL dec_prdata got %h want 0", rd); end
    checks++; if (vc !== 1) begin errors++; $display("FAIL dec_valid_cycles got %0d want 1", vc); end
  endtask

  task automatic test_timeout();
    run_xfer(16'h0010, 1'b0, 32'h0, 4'b0000, 4'b0001, 4'b0001, 0, 8'h00, {96'h0, 32'h5555_AAAA},
             pc, vc, rd, er, ad, sb, wd, dr);
    checks++; if (pc !== 5) begin errors++; $display("FAIL to_pready_cycle got %0d want 5", pc); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL to_pslverr got %b want 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL to_prdata got %h want 0", rd); end
    run_xfer(16'h0010, 1'b0, 32'h0, 4'b0000, 4'b0001, 4'b0001, 4, 8'h00, {96'h0, 32'h5555_AAAA},
             pc, vc, rd, er, ad, sb, wd, dr);
    checks++; if (pc !== 5) begin errors++; $display("FAIL to_ready_pready_cycle got %0d want 5", pc); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL to_ready_pslverr got %b want 0", er); end
    checks++; if (rd !== 32'h5555_AAAA) begin errors++; $display("FAIL to_ready_prdata got %h want 5555aaaa", rd); end
  endtask

  task automatic test_status();
    run_xfer(16'h0000, 1'b0, 32'h0, 4'b0000, 4'b0001, 4'b0001, 1, 8'b0000_0010, {96'h0, 32'h7777_7777},
             pc, vc, rd, er, ad, sb, wd, dr);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL slverr_pslverr got %b want 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL slverr_prdata got %h want 0", rd); end
    run_xfer(16'h0000, 1'b0, 32'h0, 4'b0000, 4'b0001, 4'b0001, 1, 8'b0000_0001, {96'h0, 32'h7777_7777},
             pc, vc, rd, er, ad, sb, wd, dr);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL exokay_pslverr got %b want 0", er); end
    checks++; if (rd !== 32'h7777_7777) begin errors++; $display("FAIL exokay_prdata got %h want 77777777", rd); end
    // Two active slices: data and status are OR-combined (EXOKAY | SLAVE_ERROR = DECODE_ERROR).
    run_xfer(16'h0020, 1'b0, 32'h0, 4'b0000, 4'b0011, 4'b0001, 1, 8'b0000_1001,
             {64'h0, 32'h0000_0F00, 32'h0000_00F0}, pc, vc, rd, er, ad, sb, wd, dr);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL multi_pslverr got %b want 1", er); end
    run_xfer(16'h0020, 1'b0, 32'h0, 4'b0000, 4'b0011, 4'b0010, 1, 8'b0000_0100,
             {64'h0, 32'h0000_0F00, 32'h0000_00F0}, pc, vc, rd, er, ad, sb, wd, dr);
    checks++; if (rd !== 32'h0000_0FF0) begin errors++; $display("FAIL multi_prdata got %h want 00000ff0", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL multi_ok_pslverr got %b want 0", er); end
  endtask

  task automatic test_back_to_back();
    run_xfer(16'h0004, 1'b1, 32'h1111_2222, 4'b1111, 4'b0010, 4'b0010, 1, 8'h00, 128'h0,
             pc, vc, rd, er, ad, sb, wd, dr);
    checks++; if (pc !== 2) begin errors++; $display("FAIL b2b_first_cycle got %0d want 2", pc); end
    run_xfer(16'h0008, 1'b0, 32'h0, 4'b0000, 4'b1000, 4'b1000, 1, 8'h00, {32'h9ABC_DEF0, 96'h0},
             pc, vc, rd, er, ad, sb, wd, dr);
    checks++; if (pc !== 2) begin errors++; $display("FAIL b2b_second_cycle got %0d want 2", pc); end
    checks++; if (rd !== 32'h9ABC_DEF0) begin errors++; $display("FAIL b2b_prdata got %h want 9abcdef0", rd); end
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    psel = 1; penable = 0; paddr = 16'h0030; pwrite = 0; pstrb = 0;
    @(posedge clk); #1;
    penable = 1; reg_active = 4'b0001; reg_ready = 4'b0000;
    @(posedge clk); #1;
    checks++; if (reg_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_valid_before got %b want 1", reg_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (reg_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", reg_valid); end
    checks++; if ({pready, pslverr} !== 2'b00) begin errors++; $display("FAIL rst_mid_pready_pslverr got %b want 00", {pready, pslverr}); end
    @(posedge clk); #1;
    psel = 0; penable = 0; reg_active = 0; rst = 1'b0;
    run_xfer(16'h0004, 1'b1, 32'h0BAD_F00D, 4'b1000, 4'b0010, 4'b0010, 1, 8'h00, 128'h0,
             pc, vc, rd, er, ad, sb, wd, dr);
    checks++; if (pc !== 2) begin errors++; $display("FAIL rst_after_pready_cycle got %0d want 2", pc); end
    checks++; if (sb !== 32'hFF00_0000) begin errors++; $display("FAIL rst_after_strobe got %h want ff000000", sb); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rst_after_pslverr got %b want 0", er); end
  endtask

  initial begin
    test_reset();
    test_write_hit();
    test_read_wait();
    test_decode_error();
    test_timeout();
    test_status();
    test_back_to_back();
    test_reset_mid_access();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rggen_apb_host_adapter.md
Name: rggen_apb_host_adapter

Overview:
- Bridges an APB3/APB4 slave port onto the internal register-bus consumed by register/bit-field blocks, emitting direction and status using the shared direction/status encodings (READ/WRITE; OKAY/EXOKAY/SLAVE_ERROR/DECODE_ERROR).
- Sits directly upstream of the register blocks.
- Captures one APB command, presents it until a register acknowledges, then returns read data and an error flag to the APB master.
- Provides decode-error detection and a watchdog timeout.

Parameters:
- ADDRESS_WIDTH, 16, width of i_paddr and o_reg_address.
- BUS_WIDTH, 32, data width; multiple of 8.
- REGISTERS, 4, number of downstream register slices.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before a forced SLAVE_ERROR; 0 disables the timeout.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  asynchronous active-high reset
- i_psel  input  1  APB select
- i_penable  input  1  APB enable
- i_paddr  input  ADDRESS_WIDTH  APB address
- i_pprot  input  3  APB protection (ignored)
- i_pwrite  input  1  APB direction
- i_pstrb  input  BUS_WIDTH/8  APB byte strobes
- i_pwdata  input  BUS_WIDTH  APB write data
- o_pready  output  1  APB ready
- o_prdata  output  BUS_WIDTH  APB read data
- o_pslverr  output  1  APB error
- o_reg_valid  output  1  register access request
- o_reg_direction  output  rggen_direction  request direction
- o_reg_address  output  ADDRESS_WIDTH  byte-aligned address
- o_reg_write_data  output  BUS_WIDTH  write data
- o_reg_strobe  output  BUS_WIDTH  bit-level write mask
- i_reg_active  input  REGISTERS  per-register address hit
- i_reg_ready  input  REGISTERS  per-register done
- i_reg_status  input  2*REGISTERS  per-register rggen_status
- i_reg_read_data  input  BUS_WIDTH*REGISTERS  per-register read data

Behaviour:
- Reset: asynchronous, active-high, effective mid-transfer.
  - All outputs go to 0 (o_reg_direction = RGGEN_READ).
  - FSM returns to IDLE and the timeout counter clears.
  - An in-flight APB transfer is abandoned with no response.
- FSM state IDLE:
  - On i_psel & !i_penable, capture paddr/pwrite/pwdata/pstrb and move to ACCESS.
  - o_pready stays 0.
- FSM state ACCESS:
  - o_reg_valid = 1; request fields are driven from the captured values and held stable.
  - o_reg_address has its low log2(BUS_WIDTH/8) bits forced to 0.
  - o_reg_strobe expands each captured pstrb bit to 8 bits; it is all-ones on read.
  - Exit conditions, in priority order:
    1. i_reg_active == 0: status DECODE_ERROR, read data 0.
    2. |(i_reg_active & i_reg_ready): status is the OR of the statuses of the active slices; read data is the OR of the active slices' read data.
    3. Timeout counter == TIMEOUT_CYCLES-1 and TIMEOUT_CYCLES != 0: status SLAVE_ERROR, read data 0.
  - Ready beats timeout when both occur in the same cycle.
  - On exit, latch the response and go to RESPOND; o_reg_valid drops the cycle after exit.
  - Timeout counter: increments each ACCESS cycle, clears on entry to ACCESS, and saturates.
- FSM state RESPOND:
  - o_pready = 1 for exactly one cycle.
  - o_pslverr = latched status[1].
  - o_prdata = latched data on a successful read, 0 on a write or an error.
  - Then IDLE, and all APB outputs return to 0.
- Latency:
  - Setup at T0; ACCESS at T1.
  - Earliest ready at T1 gives pready at T2, so the minimum APB transfer is 3 cycles.
  - A back-to-back setup can be accepted in the cycle after RESPOND.
- Status width rule: OR-combining multiple active slices (a decoder bug) yields OR-ed status and data; no extra error is raised.
- APB protocol violations (psel dropped mid-ACCESS) are not detected; the captured command completes normally.
- i_pprot is unused. EXOKAY maps to pslverr = 0.

Decomposition:
- Shared package (rggen_rtl_pkg) additions:
  - rggen_adapter_state enum {IDLE, ACCESS, RESPOND}.
  - Existing rggen_direction and rggen_status types, reused as-is.
- Sub-module rggen_or_reducer:
  - Parameterised WIDTH/N.
  - Reduces the masked per-slice read data and status; instantiated twice.

Test Plan:
- Write hit: paddr=0x0004, pwdata=0xA5A5_0F0F, pstrb=4'b0011, active=4'b0010, ready at T1 -> o_reg_strobe=0x0000_FFFF, direction=WRITE, pready at T2, pslverr=0.
- Read with wait: active=4'b0100, ready after 3 ACCESS cycles, data slice2=0x1234_5678 -> pready at T4, prdata=0x1234_5678, pslverr=0.
- Decode error: active=0 at T1 -> pready at T2, pslverr=1, prdata=0, o_reg_valid high only at T1.
- Timeout: TIMEOUT_CYCLES=4, active=4'b0001, never ready -> pready after 4 ACCESS cycles, pslverr=1; ready asserted on the 4th ACCESS cycle instead -> pslverr=0.
- Slave error passthrough: status slice0=SLAVE_ERROR, ready -> pslverr=1, prdata=0.
- Reset mid-ACCESS: assert i_rst at T2 asynchronously -> o_reg_valid, o_pready, o_pslverr drop immediately; the next setup after release completes normally.
